// File: rtl/mem_req_initiator.sv
// Generic single-clock FIFO: circular storage, wrapping pointers, occupancy count.
// Latency: pushed data is visible at the head the cycle after the push.
// Backpressure: the caller must not push when full or pop when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CW-1:0]    count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Queues read/write commands and runs them one at a time on the init/busy memory responder.
// Latency: rsp_valid rises CYCLES+3 after the pop, CYCLES+4 after accept into an empty idle block.
// Backpressure: cmd_ready low while the queue is full; the response is held until rsp_ready.
module mem_req_initiator #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_wr,
    input  logic [ADDR_WIDTH-1:0]             cmd_addr,
    input  logic [DATA_WIDTH-1:0]             cmd_wdata,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_wr,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic                              rsp_err,
    output logic                              mem_init,
    output logic                              mem_wr,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    input  logic                              mem_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   pending,
    output logic                              idle
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        RESP
    } state_t;

    state_t                state_q, state_d;
    cmd_t                  push_dat, head;
    logic                  push, pop;
    logic [WW-1:0]         wd_q;
    logic                  wd_inc;
    logic                  rsp_load;
    logic                  rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;

    assign cmd_ready = (pending != FULL);
    assign push      = cmd_valid & cmd_ready;
    assign push_dat  = '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
    assign idle      = (state_q == IDLE) && (pending == '0);
    assign rsp_wr    = mem_wr;

    sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head),
        .count    (pending)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        mem_init    = 1'b0;
        rsp_valid   = 1'b0;
        wd_inc      = 1'b0;
        rsp_load    = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (pending != '0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_init = 1'b1;
                state_d  = WAIT_START;
            end
            WAIT_START: begin
                wd_inc = 1'b1;
                if (mem_busy) begin
                    state_d = WAIT_DONE;
                end else if (wd_q >= WD_LAST) begin
                    state_d   = RESP;
                    rsp_load  = 1'b1;
                    rsp_err_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                wd_inc = 1'b1;
                // Completion beats the watchdog when both land on the same cycle.
                if (!mem_busy) begin
                    state_d     = RESP;
                    rsp_load    = 1'b1;
                    rsp_rdata_d = mem_wr ? '0 : mem_rdata;
                end else if (wd_q >= WD_LAST) begin
                    state_d   = RESP;
                    rsp_load  = 1'b1;
                    rsp_err_d = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Transaction fields stay put from the pop until the next pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (pop) begin
            mem_wr    <= head.wr;
            mem_addr  <= head.addr;
            mem_wdata <= head.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else if (pop) begin
            wd_q <= '0;
        end else if (wd_inc) begin
            wd_q <= wd_q + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (rsp_load) begin
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed bench for mem_req_initiator with a behavioural init/busy responder (CYCLES=3).
module tb_mem_req_initiator;
    localparam int DW     = 8;
    localparam int AW     = 8;
    localparam int DEPTH  = 4;
    localparam int TMO    = 64;
    localparam int CYC    = 3;
    localparam int NORMAL = 0;
    localparam int TIED0  = 1;
    localparam int STUCK  = 2;
    localparam int LIMIT  = 200;

    localparam logic [63:0] RST_OUTS = 64'({1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                                            8'h00, 8'h00, 3'b000, 1'b1});

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid, cmd_ready, cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_wr, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          mem_init, mem_wr, mem_busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [2:0]    pending;
    logic          idle;

    int tests = 0;
    int fails = 0;
    int mode  = NORMAL;

    always #5 clk = ~clk;

    mem_req_initiator #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_wr    (rsp_wr),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_init  (mem_init),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_busy  (mem_busy),
        .pending   (pending),
        .idle      (idle)
    );

    // Responder: busy for CYC cycles after the init cycle, read data valid the cycle busy falls.
    logic [DW-1:0] store [256];
    logic          r_busy, r_vld;
    int            r_left;
    logic [DW-1:0] r_dat;
    logic [AW-1:0] r_addr;

    always @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_vld  <= 1'b0;
            r_left <= 0;
        end else begin
            r_vld <= 1'b0;
            if (mem_init) begin
                r_busy <= 1'b1;
                r_left <= CYC - 1;
                r_addr <= mem_addr;
                if (mem_wr) store[mem_addr] <= mem_wdata;
            end else if (r_busy) begin
                if (r_left == 0) begin
                    r_busy <= 1'b0;
                    r_vld  <= 1'b1;
                    r_dat  <= store[r_addr];
                end else begin
                    r_left <= r_left - 1;
                end
            end
        end
    end

    assign mem_busy  = (mode == TIED0) ? 1'b0 : (mode == STUCK) ? 1'b1 : r_busy;
    assign mem_rdata = r_vld ? r_dat : 8'h5A;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns on the negedge following the accepting posedge.
    task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        while (!cmd_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) check("send_cmd_ready_timeout", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // k counts negedges since the accepting posedge when called straight after send().
    task automatic wait_rsp(output int k);
        k = 1;
        while (!rsp_valid && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        if (!rsp_valid) check("rsp_valid_timeout", 64'(rsp_valid), 64'd1);
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    function automatic logic [63:0] outs();
        return 64'({cmd_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err, mem_init, mem_wr,
                    mem_addr, mem_wdata, pending, idle});
    endfunction

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vt [8];

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int k;
        int seen;
        vt[0] = '{1'b1, 8'h10, 8'hA5, 8'h00};
        vt[1] = '{1'b0, 8'h10, 8'h00, 8'hA5};
        vt[2] = '{1'b1, 8'h20, 8'h3C, 8'h00};
        vt[3] = '{1'b1, 8'h21, 8'hC3, 8'h00};
        vt[4] = '{1'b0, 8'h21, 8'h00, 8'hC3};
        vt[5] = '{1'b0, 8'h20, 8'h00, 8'h3C};
        vt[6] = '{1'b1, 8'h10, 8'hFF, 8'h00};
        vt[7] = '{1'b0, 8'h10, 8'h00, 8'hFF};

        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), RST_OUTS);
        rst = 1'b0;
        @(negedge clk);

        // Single transactions from an idle block: accept-to-valid is CYC+4.
        for (int i = 0; i < 8; i++) begin
            send(vt[i].wr, vt[i].addr, vt[i].wdata);
            wait_rsp(k);
            check($sformatf("vec%0d_latency", i), 64'(k), 64'(CYC + 4));
            check($sformatf("vec%0d_rsp_wr", i), 64'(rsp_wr), 64'(vt[i].wr));
            check($sformatf("vec%0d_rsp_rdata", i), 64'(rsp_rdata), 64'(vt[i].exp_rdata));
            check($sformatf("vec%0d_rsp_err", i), 64'(rsp_err), 64'd0);
            accept();
        end

        for (int i = 0; i < 6; i++) begin
            send(1'b1, 8'(64 + i), 8'(144 + i));
            wait_rsp(k);
            accept();
        end

        // Burst of 6 reads with the consumer stalling 5 cycles per response.
        fork
            begin
                for (int i = 0; i < 6; i++) send(1'b0, 8'(64 + i), 8'h00);
            end
            begin
                int kb;
                for (int i = 0; i < 6; i++) begin
                    wait_rsp(kb);
                    if (i == 0) begin
                        check("burst_pending_full", 64'(pending), 64'd4);
                        check("burst_cmd_ready_low", 64'(cmd_ready), 64'd0);
                    end
                    check($sformatf("burst%0d_rdata", i), 64'(rsp_rdata), 64'(144 + i));
                    repeat (5) @(negedge clk);
                    check($sformatf("burst%0d_held", i),
                          64'({rsp_valid, rsp_wr, rsp_err, rsp_rdata}),
                          64'({1'b1, 1'b0, 1'b0, 8'(144 + i)}));
                    accept();
                end
            end
        join

        // Push and pop on the same edge at pending=2, then stream through to 10 commands.
        send(1'b0, 8'h40, 8'h00);
        send(1'b0, 8'h41, 8'h00);
        send(1'b0, 8'h42, 8'h00);
        wait_rsp(k);
        check("pipe0_rdata", 64'(rsp_rdata), 64'h90);
        accept();
        check("pipe_pending_before", 64'(pending), 64'd2);
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 8'h43;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("pipe_pending_after", 64'(pending), 64'd2);
        fork
            begin
                for (int c = 4; c < 10; c++) send(1'b0, 8'(64 + (c % 6)), 8'h00);
            end
            begin
                int kp;
                rsp_ready = 1'b1;
                for (int c = 1; c < 10; c++) begin
                    wait_rsp(kp);
                    check($sformatf("pipe%0d_rdata", c), 64'(rsp_rdata), 64'(144 + (c % 6)));
                    @(negedge clk);
                end
                rsp_ready = 1'b0;
            end
        join

        // Responder never starts: abort TIMEOUT cycles after entering WAIT_START.
        mode = TIED0;
        send(1'b0, 8'h33, 8'h00);
        wait_rsp(k);
        check("tied0_latency", 64'(k), 64'(TMO + 3));
        check("tied0_err", 64'(rsp_err), 64'd1);
        check("tied0_rdata", 64'(rsp_rdata), 64'd0);
        check("tied0_wr", 64'(rsp_wr), 64'd0);
        accept();
        mode = NORMAL;
        send(1'b0, 8'h40, 8'h00);
        wait_rsp(k);
        check("after_tied0_latency", 64'(k), 64'(CYC + 4));
        check("after_tied0_rdata", 64'(rsp_rdata), 64'h90);
        check("after_tied0_err", 64'(rsp_err), 64'd0);
        accept();

        // Responder never finishes.
        mode = STUCK;
        send(1'b0, 8'h41, 8'h00);
        wait_rsp(k);
        check("stuck_latency", 64'(k), 64'(TMO + 3));
        check("stuck_err", 64'(rsp_err), 64'd1);
        check("stuck_rdata", 64'(rsp_rdata), 64'd0);
        accept();
        mode = NORMAL;
        repeat (CYC + 2) @(negedge clk);

        // One-cycle reset during WAIT_DONE with three commands queued.
        send(1'b0, 8'h40, 8'h00);
        send(1'b0, 8'h41, 8'h00);
        send(1'b0, 8'h42, 8'h00);
        send(1'b0, 8'h43, 8'h00);
        check("rst_mid_pending_before", 64'(pending), 64'd3);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", outs(), RST_OUTS);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        seen      = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        rsp_ready = 1'b0;
        check("rst_mid_no_response", 64'(seen), 64'd0);
        check("rst_mid_idle_after", 64'({idle, pending}), 64'({1'b1, 3'd0}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
